btn_press_detect: RTL
=====================

# btn_press_detect

Consumer end of the slow-enable strobe: samples a raw, bouncy player button only on `slowen` ticks and emits a single-clock `press` pulse per debounced press. One instance per player sits between the board button pins and the game-scoring logic; all instances share the same `slowen` source, which pulses high for one `clk` cycle every 256 cycles.

## Interface
- `STABLE_TICKS`, default 4: consecutive `slowen` samples of equal level needed to accept a level change; legal range 2..255.
- `REPEAT_TICKS`, default 64: hold time in `slowen` ticks between auto-repeat pulses; used only with `AUTOREPEAT_EN`; legal range 1..255.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock with reset high fully initialises the block.
- `slowen`  in  1  one-cycle sample strobe, synchronous to `clk`.
- `btn`  in  1  raw button, asynchronous, active-high.
- `press`  out  1  one-cycle pulse per accepted press, or per auto-repeat.
- `level`  out  1  debounced button level.

## Operation
- Synchroniser: 2 flops, `btn` to `btn_s`, always clocked on `clk` and not gated by `slowen`. Reset value 0.
- FSM states and transitions; all transitions occur only in cycles where `slowen` is 1:
  - IDLE: `level` is 0. If `btn_s` is 1, load `cnt` with 1 and go to RISE.
  - RISE: If `btn_s` is 1, increment `cnt`; when `cnt` reaches `STABLE_TICKS`, go to HELD. If `btn_s` is 0, go to IDLE and clear `cnt`.
  - HELD: `level` is 1. If `btn_s` is 0, load `cnt` with 1 and go to FALL.
  - FALL: If `btn_s` is 0, increment `cnt`; when `cnt` reaches `STABLE_TICKS`, go to IDLE. If `btn_s` is 1, go back to HELD and clear `cnt`; no new `press` is generated.
- `press`:
  - Registered.
  - High for exactly the one `clk` cycle after the `slowen` cycle in which RISE moves to HELD.
  - Never high on two consecutive cycles.
- `level`:
  - Registered.
  - Set to 1 on the RISE-to-HELD transition.
  - Cleared to 0 on the FALL-to-IDLE transition.
  - Holds its value during RISE and FALL (hysteresis).
- `cnt` is 8 bits wide and saturates; it never wraps.
- When `slowen` is 0, the FSM, `cnt` and `level` hold their values.
- `slowen` held at 1 continuously is legal: the block then debounces at full `clk` rate.
- Reset: state IDLE, `cnt` 0, `press` 0, `level` 0, synchroniser 0, repeat counter 0. Reset takes priority over `slowen`. Reset during HELD drops `level` to 0 with no pulse; a press still held after reset is re-qualified and produces one new `press`.

## Timing
- Synchroniser latency: 2 `clk` cycles.
- Minimum latency from a clean `btn` rise to `press`: 2 cycles + `STABLE_TICKS` `slowen` ticks + 1 cycle. With `slowen` every 256 cycles and defaults, worst case is 2 + 4×256 + 1 cycles.
- `level` changes in the same cycle that `press` asserts.
- A bounce shorter than one `slowen` period that falls between samples is invisible to the block; this is by design.
- Back-to-back presses need at least 2×`STABLE_TICKS` ticks to produce 2 pulses.

## Configuration
- `AUTOREPEAT_EN`, when defined:
  - A repeat counter runs while in HELD, counting `slowen` ticks.
  - Each time it reaches `REPEAT_TICKS`, it clears and a further one-cycle `press` pulse is issued.
  - The counter clears on entry to HELD, on leaving HELD and on reset.
  - FALL pauses the counter; returning to HELD from FALL resumes it from 0.
- When not defined: one `press` per debounced press, and no repeat counter or `REPEAT_TICKS` logic is synthesised. This is the tournament build and the default.

## Structure
- The shared game package holds:
  - the FSM state enum (IDLE, RISE, HELD, FALL);
  - the `cnt` width constant of 8;
  - default `STABLE_TICKS`.
- Sub-module `btn_sync2`: 2-flop synchroniser with `clk`, `rst`, `d`, `q`; reused by the reset-button path.

## Test plan
- Reset with `btn` at 0 and `slowen` every 256 cycles -> `press` 0 and `level` 0 after the first clock.
- Clean `btn` rise held for 2000 cycles -> exactly one `press` pulse, on the clock after the 4th `slowen` sample of 1; `level` goes to 1 in the same cycle.
- `btn` toggling every 300 cycles for 3000 cycles, then held at 1 -> no `press` during toggling; one `press` after 4 stable samples.
- Release glitch in HELD (`btn` 0 for 2 samples, then 1 again) -> `level` stays 1 and no second `press`.
- Reset asserted for 1 cycle while in HELD with `btn` still 1 -> `level` goes to 0 the next cycle; one new `press` after 4 more samples.
- `AUTOREPEAT_EN` with `REPEAT_TICKS`=3 and `btn` held for 20 samples -> the first `press` plus one `press` every 3rd `slowen` tick while held; with the macro undefined -> exactly 1 `press`.

Source files
------------

// File: rtl/btn_press_detect_pkg.sv
// Shared game package for the player-button path.
// Holds the debounce FSM state enum, the debounce counter width, the default
// stable-sample count, and a saturating increment used by the counters.
package btn_press_detect_pkg;

   localparam int CNT_W            = 8;
   localparam int STABLE_TICKS_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RISE = 2'd1,
      ST_HELD = 2'd2,
      ST_FALL = 2'd3
   } state_e;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Also used on the reset-button path.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset (clears both flops)
//   d    in   asynchronous input
//   q    out  synchronised copy of d, two clk cycles late
module btn_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/btn_press_detect.sv
// Debounced player-button press detector.
// The raw button is synchronised every clk, but only examined on slowen
// ticks. A level change is accepted after STABLE_TICKS consecutive equal
// samples; each accepted press yields a one-cycle press pulse.
// Build option: define AUTOREPEAT_EN to add auto-repeat pulses every
// REPEAT_TICKS slowen ticks while the button stays held. Without it, no
// repeat counter exists.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   slowen  in   one-cycle sample strobe
//   btn     in   raw asynchronous button, active-high
//   press   out  one-cycle pulse per accepted press (or auto-repeat)
//   level   out  debounced button level
//
// state   | meaning
// IDLE    | debounced level 0, input stable low
// RISE    | level 0, counting consecutive high samples
// HELD    | level 1, input stable high
// FALL    | level 1, counting consecutive low samples
module btn_press_detect
   import btn_press_detect_pkg::*;
#(
   parameter int STABLE_TICKS = STABLE_TICKS_DEF,
   parameter int REPEAT_TICKS = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic slowen,
   input  logic btn,
   output logic press,
   output logic level
);

   if (STABLE_TICKS < 2 || STABLE_TICKS > 255 ||
       REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_param_check
      $error("btn_press_detect: STABLE_TICKS or REPEAT_TICKS out of range");
   end

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);

   logic             btn_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             enter_held;
   logic             rpt_fire;

   btn_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (btn_s)
   );

   assign cnt_inc = sat_inc(cnt_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      enter_held = 1'b0;
      if (slowen) begin
         case (state_q)
            ST_IDLE: begin
               if (btn_s) begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_RISE;
               end
            end
            ST_RISE: begin
               if (!btn_s) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else if (cnt_inc == STABLE_C) begin
                  cnt_d      = '0;
                  state_d    = ST_HELD;
                  level_d    = 1'b1;
                  enter_held = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_HELD: begin
               if (!btn_s) begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_FALL;
               end
            end
            ST_FALL: begin
               // Bounce back to high during release: no new press.
               if (btn_s) begin
                  cnt_d   = '0;
                  state_d = ST_HELD;
               end else if (cnt_inc == STABLE_C) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
                  level_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

`ifdef AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);

   logic [CNT_W-1:0] rpt_q, rpt_d, rpt_inc;

   assign rpt_inc = sat_inc(rpt_q);

   // Counts only ticks spent steadily in HELD; any other tick (RISE, FALL,
   // or the tick that leaves HELD) restarts it from zero.
   always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (slowen) begin
         if (state_q == ST_HELD && btn_s) begin
            if (rpt_inc == REPEAT_C) begin
               rpt_d    = '0;
               rpt_fire = 1'b1;
            end else begin
               rpt_d = rpt_inc;
            end
         end else begin
            rpt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Masking with press_q keeps pulses apart even with slowen stuck high.
   assign press_d = (enter_held | rpt_fire) & ~press_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;
   assign level = level_q;

endmodule
